// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus definitions: master indices and bus field widths.
// Reused by the arbiter and the DMA engine.
package dbus_arbiter_pkg;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/dbus_arb_grant.sv
// Grant selection for the two-master data-bus arbiter: fixed CPU priority
// with a starvation bound that forces a DMA slot after STARVE_LIMIT CPU accepts.
module dbus_arb_grant
  import dbus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       sNak,
  input  logic       accept,
  output logic       grant
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             grant_d, grant_q;
  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_d = grant_q;
    if (!sNak) begin
      unique case (req)
        2'b11:   grant_d = (starve_cnt_q == LIMIT) ? M_DMA : M_CPU;
        2'b01:   grant_d = M_CPU;
        2'b10:   grant_d = M_DMA;
        default: grant_d = grant_q;
      endcase
    end
  end

  // Counts CPU wins only while the DMA is actually waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req[M_DMA] || (accept && grant_d == M_DMA)) begin
      starve_cnt_d = '0;
    end else if (accept && grant_d == M_CPU && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= M_CPU;
      starve_cnt_q <= '0;
    end else begin
      grant_q      <= grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign grant = grant_d;

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master (CPU, DMA) arbiter in front of the data-bus decoder using the
// one-deep pipelined slave protocol; routes requests and tracks the response owner.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0Addr,
  input  logic              m0EN,
  input  logic              m0WE,
  input  logic [DATA_W-1:0] m0WData,
  input  logic [BE_W-1:0]   m0BE,
  output logic [DATA_W-1:0] m0Data,
  output logic              m0Nak,
  input  logic [ADDR_W-1:0] m1Addr,
  input  logic              m1EN,
  input  logic              m1WE,
  input  logic [DATA_W-1:0] m1WData,
  input  logic [BE_W-1:0]   m1BE,
  output logic [DATA_W-1:0] m1Data,
  output logic              m1Nak,
  output logic [ADDR_W-1:0] sAddr,
  output logic              sEN,
  output logic              sWE,
  output logic [DATA_W-1:0] sWData,
  output logic [BE_W-1:0]   sBE,
  input  logic [DATA_W-1:0] sData,
  input  logic              sNak
);

  logic grant;
  logic accept;
  logic resp_valid_d, resp_valid_q;
  logic resp_owner_d, resp_owner_q;

  dbus_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_grant (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1EN, m0EN}),
    .sNak   (sNak),
    .accept (accept),
    .grant  (grant)
  );

  // Pure mux of the granted master; no added latency on the request path.
  assign sAddr  = (grant == M_DMA) ? m1Addr  : m0Addr;
  assign sEN    = (grant == M_DMA) ? m1EN    : m0EN;
  assign sWE    = (grant == M_DMA) ? m1WE    : m0WE;
  assign sWData = (grant == M_DMA) ? m1WData : m0WData;
  assign sBE    = (grant == M_DMA) ? m1BE    : m0BE;

  assign accept = sEN & ~sNak;

  // A stall freezes the pending response; otherwise it tracks this cycle's accept.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_owner_d = resp_owner_q;
    if (!sNak) begin
      resp_valid_d = accept;
      if (accept) begin
        resp_owner_d = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= M_CPU;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign m0Data = (resp_valid_q && resp_owner_q == M_CPU) ? sData : '0;
  assign m1Data = (resp_valid_q && resp_owner_q == M_DMA) ? sData : '0;

  assign m0Nak = (resp_valid_q & (resp_owner_q == M_CPU) & sNak) | (m0EN & (grant != M_CPU));
  assign m1Nak = (resp_valid_q & (resp_owner_q == M_DMA) & sNak) | (m1EN & (grant != M_DMA));

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: a cycle-by-cycle vector table plus
// hand-written reset and starvation-recovery sequences.
module tb_dbus_arbiter;

  localparam logic [31:0] CPU_WD = 32'h0C0C_0C0C;

  logic        clk, rst;
  logic [31:0] m0Addr, m0WData, m0Data;
  logic        m0EN, m0WE, m0Nak;
  logic [3:0]  m0BE;
  logic [31:0] m1Addr, m1WData, m1Data;
  logic        m1EN, m1WE, m1Nak;
  logic [3:0]  m1BE;
  logic [31:0] sAddr, sWData, sData;
  logic        sEN, sWE, sNak;
  logic [3:0]  sBE;

  int n_tests = 0;
  int n_fail  = 0;

  dbus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0Addr(m0Addr), .m0EN(m0EN), .m0WE(m0WE), .m0WData(m0WData), .m0BE(m0BE),
    .m0Data(m0Data), .m0Nak(m0Nak),
    .m1Addr(m1Addr), .m1EN(m1EN), .m1WE(m1WE), .m1WData(m1WData), .m1BE(m1BE),
    .m1Data(m1Data), .m1Nak(m1Nak),
    .sAddr(sAddr), .sEN(sEN), .sWE(sWE), .sWData(sWData), .sBE(sBE),
    .sData(sData), .sNak(sNak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        m0_en;
    logic [31:0] m0_addr;
    logic        m1_en, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_be;
    logic        s_nak;
    logic [31:0] s_data;
    logic        e_sen;
    logic [31:0] e_saddr;
    logic        e_swe;
    logic [31:0] e_swdata;
    logic [3:0]  e_sbe;
    logic        e_m0nak, e_m1nak;
    logic [31:0] e_m0data, e_m1data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic m0_en, input logic [31:0] m0_addr,
                     input logic m1_en, input logic m1_we, input logic [31:0] m1_addr,
                     input logic [31:0] m1_wdata, input logic [3:0] m1_be,
                     input logic s_nak, input logic [31:0] s_data,
                     input logic e_sen, input logic [31:0] e_saddr, input logic e_swe,
                     input logic [31:0] e_swdata, input logic [3:0] e_sbe,
                     input logic e_m0nak, input logic e_m1nak,
                     input logic [31:0] e_m0data, input logic [31:0] e_m1data);
    vec_t v;
    v.name = name; v.m0_en = m0_en; v.m0_addr = m0_addr;
    v.m1_en = m1_en; v.m1_we = m1_we; v.m1_addr = m1_addr; v.m1_wdata = m1_wdata; v.m1_be = m1_be;
    v.s_nak = s_nak; v.s_data = s_data;
    v.e_sen = e_sen; v.e_saddr = e_saddr; v.e_swe = e_swe; v.e_swdata = e_swdata; v.e_sbe = e_sbe;
    v.e_m0nak = e_m0nak; v.e_m1nak = e_m1nak; v.e_m0data = e_m0data; v.e_m1data = e_m1data;
    vecs.push_back(v);
  endtask

  task automatic set_in(input logic e0, input logic [31:0] a0, input logic e1, input logic we1,
                        input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] be1,
                        input logic nak, input logic [31:0] sd);
    m0EN = e0; m0Addr = a0; m1EN = e1; m1WE = we1; m1Addr = a1; m1WData = wd1; m1BE = be1;
    sNak = nak; sData = sd;
  endtask

  task automatic check_outs(input string tag, input logic sen, input logic [31:0] saddr,
                            input logic m0nak, input logic m1nak,
                            input logic [31:0] m0d, input logic [31:0] m1d);
    check({tag, ".sEN"},    32'(sEN),   32'(sen));
    check({tag, ".sAddr"},  sAddr,      saddr);
    check({tag, ".m0Nak"},  32'(m0Nak), 32'(m0nak));
    check({tag, ".m1Nak"},  32'(m1Nak), 32'(m1nak));
    check({tag, ".m0Data"}, m0Data,     m0d);
    check({tag, ".m1Data"}, m1Data,     m1d);
  endtask

  initial begin
    // name      m0en m0addr        m1en we m1addr        m1wdata       be    nak sdata
    //           | sen saddr        swe swdata         sbe   m0nak m1nak m0data m1data
    add("idle0",     0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,
                     0, 32'h0,         0, CPU_WD,         4'hF, 0, 0, 32'h0,  32'h0);
    add("cpu_rd0",   1, 32'hBFC0_0000, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h99,
                     1, 32'hBFC0_0000, 0, CPU_WD,         4'hF, 0, 0, 32'h0,  32'h0);
    add("cpu_rd1",   1, 32'hBFC0_0004, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h11,
                     1, 32'hBFC0_0004, 0, CPU_WD,         4'hF, 0, 0, 32'h11, 32'h0);
    add("cpu_rsp1",  0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h22,
                     0, 32'h0,         0, CPU_WD,         4'hF, 0, 0, 32'h22, 32'h0);
    add("both0",     1, 32'h0000_1000, 1, 0, 32'h8000_0100, 32'h0,         4'hF, 0, 32'h31,
                     1, 32'h0000_1000, 0, CPU_WD,         4'hF, 0, 1, 32'h0,  32'h0);
    add("both1",     1, 32'h0000_1004, 1, 0, 32'h8000_0100, 32'h0,         4'hF, 0, 32'h32,
                     1, 32'h0000_1004, 0, CPU_WD,         4'hF, 0, 1, 32'h32, 32'h0);
    add("both2",     1, 32'h0000_1008, 1, 0, 32'h8000_0100, 32'h0,         4'hF, 0, 32'h33,
                     1, 32'h0000_1008, 0, CPU_WD,         4'hF, 0, 1, 32'h33, 32'h0);
    add("both3",     1, 32'h0000_100C, 1, 0, 32'h8000_0100, 32'h0,         4'hF, 0, 32'h34,
                     1, 32'h0000_100C, 0, CPU_WD,         4'hF, 0, 1, 32'h34, 32'h0);
    add("starve",    1, 32'h0000_1010, 1, 0, 32'h8000_0100, 32'h0,         4'hF, 0, 32'h35,
                     1, 32'h8000_0100, 0, 32'h0,          4'hF, 1, 0, 32'h35, 32'h0);
    add("cpu_back",  1, 32'h0000_1010, 1, 0, 32'h8000_0100, 32'h0,         4'hF, 0, 32'h36,
                     1, 32'h0000_1010, 0, CPU_WD,         4'hF, 0, 1, 32'h0,  32'h36);
    add("idle1",     0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h37,
                     0, 32'h0,         0, CPU_WD,         4'hF, 0, 0, 32'h37, 32'h0);
    add("dma_rd",    0, 32'h0,         1, 0, 32'h8000_0200, 32'h0,         4'hF, 0, 32'h0,
                     1, 32'h8000_0200, 0, 32'h0,          4'hF, 0, 0, 32'h0,  32'h0);
    add("stall1",    1, 32'h0000_2000, 0, 0, 32'h8000_0200, 32'h0,         4'hF, 1, 32'hAA,
                     0, 32'h8000_0200, 0, 32'h0,          4'hF, 1, 1, 32'h0,  32'hAA);
    add("stall2",    1, 32'h0000_2000, 0, 0, 32'h8000_0200, 32'h0,         4'hF, 1, 32'hAB,
                     0, 32'h8000_0200, 0, 32'h0,          4'hF, 1, 1, 32'h0,  32'hAB);
    add("stall3",    1, 32'h0000_2000, 0, 0, 32'h8000_0200, 32'h0,         4'hF, 1, 32'hAC,
                     0, 32'h8000_0200, 0, 32'h0,          4'hF, 1, 1, 32'h0,  32'hAC);
    add("stall_end", 1, 32'h0000_2000, 0, 0, 32'h8000_0200, 32'h0,         4'hF, 0, 32'h5A,
                     1, 32'h0000_2000, 0, CPU_WD,         4'hF, 0, 0, 32'h0,  32'h5A);
    add("idle2",     0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h6B,
                     0, 32'h0,         0, CPU_WD,         4'hF, 0, 0, 32'h6B, 32'h0);
    add("dma_wr",    0, 32'h0,         1, 1, 32'hBFE0_0010, 32'hDEAD_BEEF, 4'h3, 0, 32'h0,
                     1, 32'hBFE0_0010, 1, 32'hDEAD_BEEF,  4'h3, 0, 0, 32'h0,  32'h0);
    add("park1",     0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h77,
                     0, 32'h0,         0, 32'h0,          4'h0, 0, 0, 32'h0,  32'h77);
    add("park2",     0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h12,
                     0, 32'h0,         0, 32'h0,          4'h0, 0, 0, 32'h0,  32'h0);
    add("cpu_lone",  1, 32'hBFC0_0008, 0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,
                     1, 32'hBFC0_0008, 0, CPU_WD,         4'hF, 0, 0, 32'h0,  32'h0);
    add("idle3",     0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h44,
                     0, 32'h0,         0, CPU_WD,         4'hF, 0, 0, 32'h44, 32'h0);

    m0WE = 1'b0; m0WData = CPU_WD; m0BE = 4'hF;
    set_in(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h5555_5555);
    rst = 1'b1;
    @(negedge clk);
    check_outs("in_reset", 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].m0_en, vecs[i].m0_addr, vecs[i].m1_en, vecs[i].m1_we, vecs[i].m1_addr,
             vecs[i].m1_wdata, vecs[i].m1_be, vecs[i].s_nak, vecs[i].s_data);
      @(negedge clk);
      check_outs(vecs[i].name, vecs[i].e_sen, vecs[i].e_saddr, vecs[i].e_m0nak,
                 vecs[i].e_m1nak, vecs[i].e_m0data, vecs[i].e_m1data);
      check({vecs[i].name, ".sWE"},    32'(sWE), 32'(vecs[i].e_swe));
      check({vecs[i].name, ".sWData"}, sWData,   vecs[i].e_swdata);
      check({vecs[i].name, ".sBE"},    32'(sBE), 32'(vecs[i].e_sbe));
      @(posedge clk); #1;
    end

    // Reset landing mid-cycle while a DMA response is pending and stalled.
    set_in(0, 32'h0, 1, 0, 32'h8000_0300, 32'h0, 4'hF, 0, 32'h0);
    @(posedge clk); #1;
    set_in(1, 32'h0000_3000, 1, 0, 32'h8000_0300, 32'h0, 4'hF, 1, 32'hFF);
    @(negedge clk);
    check_outs("pre_rst", 1, 32'h8000_0300, 1, 1, 32'h0, 32'hFF);
    #1 rst = 1'b1;
    set_in(0, 32'h0, 0, 0, 32'h8000_0300, 32'h0, 4'hF, 1, 32'hFF);
    #1;
    check_outs("rst_idle", 0, 32'h0, 0, 0, 32'h0, 32'h0);
    set_in(1, 32'h0000_3000, 1, 0, 32'h8000_0300, 32'h0, 4'hF, 1, 32'hFF);
    #1;
    check_outs("rst_frozen", 1, 32'h0000_3000, 0, 1, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Build up starvation credit, then reset: the CPU must again win four times.
    set_in(1, 32'h0000_3000, 1, 0, 32'h8000_0300, 32'h0, 4'hF, 0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) check_outs($sformatf("restarve%0d", k), 1, 32'h0000_3000, 0, 1, 32'(k > 0) * 32'h0, 32'h0);
      else       check_outs("restarve_dma", 1, 32'h8000_0300, 1, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
